// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU/branch/multiply plus a 32-cycle restoring divider.
// All outputs are registered; busy stalls the pipeline while a divide is in flight.
module exec_unit (
    input  logic        stg_clk,
    input  logic        reset,
    input  logic        stg_ena,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd,
    input  logic [9:0]  funct,
    input  logic [6:0]  opcode,
    input  logic        save_to_reg,
    input  logic        immediate_used,
    input  logic        is_branch,
    input  logic        rd_memory,
    input  logic        wr_memory,
    output logic [31:0] result_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  rd_out,
    output logic        save_to_reg_out,
    output logic        rd_memory_out,
    output logic        wr_memory_out,
    output logic        valid_out,
    output logic        branch_taken_out,
    output logic [31:0] branch_target_out,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    state_e      state_q;
    logic [4:0]  div_cnt_q;
    logic [31:0] div_quo_q;
    logic [31:0] div_rem_q;
    logic [31:0] div_dsr_q;
    logic [31:0] div_dividend_q;
    logic [31:0] div_store_q;
    logic        div_want_rem_q;
    logic        div_neg_quo_q;
    logic        div_neg_rem_q;
    logic        div_by_zero_q;
    logic [4:0]  div_rd_q;
    logic        div_save_q;
    logic        div_rdm_q;
    logic        div_wrm_q;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        is_mext;
    logic        is_div;

    assign funct3  = funct[2:0];
    assign funct7  = funct[9:3];
    assign op_b    = immediate_used ? imm : rs2_data;
    assign shamt   = op_b[4:0];
    assign is_mext = (opcode == OpcOp) && (funct7 == 7'b0000001);
    assign is_div  = is_mext && funct3[2];

    assign busy = (state_q != StIdle);

    // Base integer ALU; funct[8] selects SUB only for register-register ops.
    logic [31:0] alu_res;
    always_comb begin
        alu_res = '0;
        unique case (funct3)
            3'b000:  alu_res = (opcode == OpcOp && funct[8]) ? rs1_data - op_b : rs1_data + op_b;
            3'b001:  alu_res = rs1_data << shamt;
            3'b010:  alu_res = {31'b0, $signed(rs1_data) < $signed(op_b)};
            3'b011:  alu_res = {31'b0, rs1_data < op_b};
            3'b100:  alu_res = rs1_data ^ op_b;
            3'b101:  alu_res = funct[8] ? $unsigned($signed(rs1_data) >>> shamt)
                                        : rs1_data >> shamt;
            3'b110:  alu_res = rs1_data | op_b;
            3'b111:  alu_res = rs1_data & op_b;
            default: alu_res = '0;
        endcase
    end

    // 33-bit operands let one signed multiplier cover all four signedness variants.
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [63:0] mul_prod;
    logic [31:0]        mul_res;

    assign mul_a    = {(funct3[1:0] != 2'b11) & rs1_data[31], rs1_data};
    assign mul_b    = {(funct3[1:0] == 2'b01) & op_b[31], op_b};
    assign mul_prod = 64'(mul_a) * 64'(mul_b);
    assign mul_res  = (funct3[1:0] == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];

    logic br_cond;
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (rs1_data == rs2_data);
            3'b001:  br_cond = (rs1_data != rs2_data);
            3'b100:  br_cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  br_cond = (rs1_data <  rs2_data);
            3'b111:  br_cond = (rs1_data >= rs2_data);
            default: br_cond = 1'b0;
        endcase
    end

    logic [31:0] addr_sum;
    logic [31:0] exe_res;
    logic [31:0] exe_target;
    logic        exe_taken;

    assign addr_sum = rs1_data + imm;

    always_comb begin
        exe_res    = '0;
        exe_target = pc + imm;
        exe_taken  = is_branch & br_cond;
        case (opcode)
            OpcOp:             exe_res = is_mext ? mul_res : alu_res;
            OpcOpImm:          exe_res = alu_res;
            OpcLui:            exe_res = imm;
            OpcAuipc:          exe_res = pc + imm;
            OpcLoad, OpcStore: exe_res = addr_sum;
            OpcJal: begin
                exe_res   = pc + 32'd4;
                exe_taken = 1'b1;
            end
            OpcJalr: begin
                exe_res    = pc + 32'd4;
                exe_taken  = 1'b1;
                exe_target = addr_sum & ~32'd1;
            end
            default: exe_res = '0;
        endcase
    end

    // Divider operands are captured as magnitudes; signs are reapplied in DONE.
    logic        div_signed;
    logic [31:0] rs1_mag;
    logic [31:0] rs2_mag;

    assign div_signed = ~funct3[0];
    assign rs1_mag    = (div_signed && rs1_data[31]) ? -rs1_data : rs1_data;
    assign rs2_mag    = (div_signed && rs2_data[31]) ? -rs2_data : rs2_data;

    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] div_res;

    assign rem_shift = {div_rem_q, div_quo_q[31]};
    assign rem_diff  = rem_shift - {1'b0, div_dsr_q};
    assign quo_fix   = div_neg_quo_q ? -div_quo_q : div_quo_q;
    assign rem_fix   = div_neg_rem_q ? -div_rem_q : div_rem_q;

    always_comb begin
        if (div_by_zero_q) begin
            div_res = div_want_rem_q ? div_dividend_q : 32'hFFFF_FFFF;
        end else begin
            div_res = div_want_rem_q ? rem_fix : quo_fix;
        end
    end

    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            state_q           <= StIdle;
            div_cnt_q         <= '0;
            div_quo_q         <= '0;
            div_rem_q         <= '0;
            div_dsr_q         <= '0;
            div_dividend_q    <= '0;
            div_store_q       <= '0;
            div_want_rem_q    <= 1'b0;
            div_neg_quo_q     <= 1'b0;
            div_neg_rem_q     <= 1'b0;
            div_by_zero_q     <= 1'b0;
            div_rd_q          <= '0;
            div_save_q        <= 1'b0;
            div_rdm_q         <= 1'b0;
            div_wrm_q         <= 1'b0;
            result_out        <= '0;
            store_data_out    <= '0;
            rd_out            <= '0;
            save_to_reg_out   <= 1'b0;
            rd_memory_out     <= 1'b0;
            wr_memory_out     <= 1'b0;
            valid_out         <= 1'b0;
            branch_taken_out  <= 1'b0;
            branch_target_out <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (stg_ena && is_div) begin
                        state_q          <= StDiv;
                        div_cnt_q        <= '0;
                        div_quo_q        <= rs1_mag;
                        div_rem_q        <= '0;
                        div_dsr_q        <= rs2_mag;
                        div_dividend_q   <= rs1_data;
                        div_store_q      <= rs2_data;
                        div_want_rem_q   <= funct3[1];
                        div_neg_quo_q    <= div_signed & (rs1_data[31] ^ rs2_data[31]);
                        div_neg_rem_q    <= div_signed & rs1_data[31];
                        div_by_zero_q    <= (rs2_data == 32'd0);
                        div_rd_q         <= rd;
                        div_save_q       <= save_to_reg;
                        div_rdm_q        <= rd_memory;
                        div_wrm_q        <= wr_memory;
                        valid_out        <= 1'b0;
                        save_to_reg_out  <= 1'b0;
                        rd_memory_out    <= 1'b0;
                        wr_memory_out    <= 1'b0;
                        branch_taken_out <= 1'b0;
                    end else if (stg_ena) begin
                        result_out        <= exe_res;
                        store_data_out    <= rs2_data;
                        rd_out            <= rd;
                        save_to_reg_out   <= save_to_reg;
                        rd_memory_out     <= rd_memory;
                        wr_memory_out     <= wr_memory;
                        valid_out         <= 1'b1;
                        branch_taken_out  <= exe_taken;
                        branch_target_out <= exe_target;
                    end
                end
                StDiv: begin
                    // Quotient bits shift in where dividend bits shift out.
                    if (!rem_diff[32]) begin
                        div_rem_q <= rem_diff[31:0];
                        div_quo_q <= {div_quo_q[30:0], 1'b1};
                    end else begin
                        div_rem_q <= rem_shift[31:0];
                        div_quo_q <= {div_quo_q[30:0], 1'b0};
                    end
                    div_cnt_q <= div_cnt_q + 5'd1;
                    if (div_cnt_q == 5'd31) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    result_out       <= div_res;
                    store_data_out   <= div_store_q;
                    rd_out           <= div_rd_q;
                    save_to_reg_out  <= div_save_q;
                    rd_memory_out    <= div_rdm_q;
                    wr_memory_out    <= div_wrm_q;
                    valid_out        <= 1'b1;
                    branch_taken_out <= 1'b0;
                    div_cnt_q        <= '0;
                    state_q          <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Randomized self-checking bench for exec_unit against an arithmetic reference model.
module tb_exec_unit;

    logic        stg_clk = 1'b0;
    logic        reset;
    logic        stg_ena;
    logic [31:0] pc, imm, rs1_data, rs2_data;
    logic [4:0]  rd;
    logic [9:0]  funct;
    logic [6:0]  opcode;
    logic        save_to_reg, immediate_used, is_branch, rd_memory, wr_memory;
    logic [31:0] result_out, store_data_out, branch_target_out;
    logic [4:0]  rd_out;
    logic        save_to_reg_out, rd_memory_out, wr_memory_out, valid_out;
    logic        branch_taken_out, busy;

    exec_unit dut (
        .stg_clk           (stg_clk),
        .reset             (reset),
        .stg_ena           (stg_ena),
        .pc                (pc),
        .imm               (imm),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .rd                (rd),
        .funct             (funct),
        .opcode            (opcode),
        .save_to_reg       (save_to_reg),
        .immediate_used    (immediate_used),
        .is_branch         (is_branch),
        .rd_memory         (rd_memory),
        .wr_memory         (wr_memory),
        .result_out        (result_out),
        .store_data_out    (store_data_out),
        .rd_out            (rd_out),
        .save_to_reg_out   (save_to_reg_out),
        .rd_memory_out     (rd_memory_out),
        .wr_memory_out     (wr_memory_out),
        .valid_out         (valid_out),
        .branch_taken_out  (branch_taken_out),
        .branch_target_out (branch_target_out),
        .busy              (busy)
    );

    always #5 stg_clk = ~stg_clk;

    typedef struct {
        logic [31:0] result;
        logic [31:0] target;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        taken, valid, save, rdm, wrm;
        logic        chk_result, chk_target;
    } exp_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    endtask

    task automatic step();
        @(posedge stg_clk);
        #1;
    endtask

    task automatic check_exp(input string tag, input exp_t e);
        if (e.chk_result) check({tag, ".result"}, result_out, e.result);
        if (e.chk_target) check({tag, ".target"}, branch_target_out, e.target);
        check({tag, ".valid"}, 32'(valid_out), 32'(e.valid));
        check({tag, ".taken"}, 32'(branch_taken_out), 32'(e.taken));
        check({tag, ".rd"}, 32'(rd_out), 32'(e.rd));
        check({tag, ".save"}, 32'(save_to_reg_out), 32'(e.save));
        check({tag, ".rdm"}, 32'(rd_memory_out), 32'(e.rdm));
        check({tag, ".wrm"}, 32'(wr_memory_out), 32'(e.wrm));
        check({tag, ".store"}, store_data_out, e.store);
    endtask

    // Reference semantics for all single-cycle ops, from the ISA definitions.
    function automatic exp_t model();
        exp_t            e;
        logic [31:0]     b;
        int unsigned     sh;
        longint          sp;
        longint unsigned up;
        e = '{default: '0};
        b = immediate_used ? imm : rs2_data;
        sh = int'(b[4:0]);
        e.valid = 1'b1; e.save = save_to_reg; e.rdm = rd_memory; e.wrm = wr_memory;
        e.rd = rd; e.store = rs2_data; e.chk_result = 1'b1;
        case (opcode)
            7'h33, 7'h13: begin
                if (opcode == 7'h33 && funct[9:3] == 7'h01) begin
                    case (funct[2:0])
                        3'd0: begin up = longint'(rs1_data) * longint'(b); e.result = up[31:0]; end
                        3'd1: begin sp = longint'($signed(rs1_data)) * longint'($signed(b));
                                    e.result = sp[63:32]; end
                        3'd2: begin sp = longint'($signed(rs1_data)) * longint'({32'b0, b});
                                    e.result = sp[63:32]; end
                        default: begin up = longint'({32'b0, rs1_data}) * longint'({32'b0, b});
                                       e.result = up[63:32]; end
                    endcase
                end else begin
                    case (funct[2:0])
                        3'd0: e.result = (opcode == 7'h33 && funct[8]) ? rs1_data - b
                                                                       : rs1_data + b;
                        3'd1: e.result = rs1_data << sh;
                        3'd2: e.result = ($signed(rs1_data) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd3: e.result = (rs1_data < b) ? 32'd1 : 32'd0;
                        3'd4: e.result = rs1_data ^ b;
                        3'd5: e.result = funct[8] ? 32'($signed(rs1_data) >>> sh) : rs1_data >> sh;
                        3'd6: e.result = rs1_data | b;
                        default: e.result = rs1_data & b;
                    endcase
                end
            end
            7'h37: e.result = imm;
            7'h17: e.result = pc + imm;
            7'h03, 7'h23: e.result = rs1_data + imm;
            7'h6f: begin e.result = pc + 4; e.taken = 1; e.target = pc + imm; e.chk_target = 1; end
            7'h67: begin e.result = pc + 4; e.taken = 1; e.chk_target = 1;
                         e.target = (rs1_data + imm) & 32'hFFFF_FFFE; end
            7'h63: begin
                e.chk_result = 1'b0; e.chk_target = 1'b1; e.target = pc + imm;
                case (funct[2:0])
                    3'd0: e.taken = (rs1_data == rs2_data);
                    3'd1: e.taken = (rs1_data != rs2_data);
                    3'd4: e.taken = ($signed(rs1_data) < $signed(rs2_data));
                    3'd5: e.taken = ($signed(rs1_data) >= $signed(rs2_data));
                    3'd6: e.taken = (rs1_data < rs2_data);
                    default: e.taken = (rs1_data >= rs2_data);
                endcase
            end
            default: e.result = 32'd0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] div_model(input logic [31:0] a, b, input logic [2:0] f3);
        int sa, sb;
        sa = int'(a); sb = int'(b);
        if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : a;
            return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f3[1] ? a % b : a / b;
    endfunction

    task automatic clear_ins();
        pc = 0; imm = 0; rs1_data = 0; rs2_data = 0; rd = 0; funct = 0; opcode = 0;
        save_to_reg = 0; immediate_used = 0; is_branch = 0; rd_memory = 0; wr_memory = 0;
    endtask

    task automatic scramble();
        pc = $urandom; imm = $urandom; rs1_data = $urandom; rs2_data = $urandom;
        rd = 5'($urandom); funct = 10'($urandom); opcode = 7'($urandom);
        save_to_reg = 1'($urandom); immediate_used = 1'($urandom); is_branch = 1'($urandom);
        rd_memory = 1'($urandom); wr_memory = 1'($urandom); stg_ena = 1'($urandom);
    endtask

    task automatic gen_rand();
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] bf [6];
        bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        clear_ins();
        stg_ena = 1'b1;
        pc = $urandom & 32'hFFFF_FFFC;
        imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
        rs1_data = $urandom;
        rs2_data = ($urandom_range(0, 3) == 0) ? rs1_data : $urandom;
        rd = 5'($urandom);
        f3 = 3'($urandom);
        f7 = 7'h00;
        case ($urandom_range(0, 9))
            0: begin opcode = 7'h33; save_to_reg = 1;
                     if ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) f7 = 7'h20; end
            1: begin opcode = 7'h13; save_to_reg = 1; immediate_used = 1;
                     f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00; end
            2: begin opcode = 7'h37; save_to_reg = 1; immediate_used = 1; end
            3: begin opcode = 7'h17; save_to_reg = 1; immediate_used = 1; end
            4: begin opcode = 7'h03; save_to_reg = 1; immediate_used = 1; rd_memory = 1; end
            5: begin opcode = 7'h23; immediate_used = 1; wr_memory = 1; end
            6: begin opcode = 7'h6f; save_to_reg = 1; end
            7: begin opcode = 7'h67; save_to_reg = 1; immediate_used = 1; end
            8: begin opcode = 7'h63; is_branch = 1; f3 = bf[$urandom_range(0, 5)]; end
            default: begin opcode = 7'h33; save_to_reg = 1; f7 = 7'h01; f3 = 3'($urandom_range(0, 3)); end
        endcase
        funct = {f7, f3};
    endtask

    task automatic do_div(input logic [31:0] a, b, input logic [2:0] f3,
                          input logic [31:0] want, output exp_t e);
        int n;
        clear_ins();
        stg_ena = 1; opcode = 7'h33; funct = {7'h01, f3}; rs1_data = a; rs2_data = b;
        pc = $urandom; imm = $urandom; save_to_reg = 1; rd = 5'($urandom);
        e = '{default: '0};
        e.result = want; e.valid = 1; e.rd = rd; e.save = 1; e.store = b; e.chk_result = 1;
        step();
        check("div.bubble_valid", 32'(valid_out), 32'd0);
        check("div.busy", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 100) begin
            scramble();
            n++;
            step();
        end
        check("div.busy_cycles", 32'(n), 32'd33);
        check_exp("div", e);
    endtask

    initial begin
        exp_t e, last;
        logic [2:0] f3;
        logic [31:0] a, b;
        clear_ins();
        stg_ena = 0;
        reset = 1;
        step();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.valid", 32'(valid_out), 32'd0);
        check("rst.result", result_out, 32'd0);
        check("rst.target", branch_target_out, 32'd0);
        reset = 0;
        step();
        check("idle_noena.valid", 32'(valid_out), 32'd0);

        // ADD 5 + (-2)
        clear_ins(); stg_ena = 1; opcode = 7'h33; rs1_data = 5; rs2_data = 32'hFFFF_FFFE;
        step();
        check("add.result", result_out, 32'd3);
        check("add.valid", 32'(valid_out), 32'd1);

        // BLT -1 < 1
        clear_ins(); stg_ena = 1; opcode = 7'h63; funct = 10'b100; is_branch = 1;
        rs1_data = 32'hFFFF_FFFF; rs2_data = 1; pc = 32'h100; imm = 32'h20;
        step();
        check("blt.taken", 32'(branch_taken_out), 32'd1);
        check("blt.target", branch_target_out, 32'h120);

        do_div(32'hFFFF_FFF9, 32'd2, 3'b100, 32'hFFFF_FFFD, e);
        do_div(32'hFFFF_FFF9, 32'd2, 3'b110, 32'hFFFF_FFFF, e);
        do_div(32'd7, 32'd0, 3'b101, 32'hFFFF_FFFF, e);
        do_div(32'd7, 32'd0, 3'b111, 32'd7, e);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 32'h8000_0000, e);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 32'd0, e);
        do_div(32'hFFFF_FFF9, 32'd0, 3'b100, 32'hFFFF_FFFF, e);
        do_div(32'hFFFF_FFF9, 32'd0, 3'b110, 32'hFFFF_FFF9, e);
        do_div(32'd7, 32'hFFFF_FFFE, 3'b110, 32'd1, e);

        // MULHU then a held cycle
        clear_ins(); stg_ena = 1; opcode = 7'h33; funct = {7'h01, 3'b011};
        rs1_data = 32'hFFFF_FFFF; rs2_data = 32'hFFFF_FFFF;
        step();
        check("mulhu.result", result_out, 32'hFFFF_FFFE);
        scramble(); stg_ena = 0;
        step();
        check("hold.result", result_out, 32'hFFFF_FFFE);
        check("hold.valid", 32'(valid_out), 32'd1);

        // Reset in the middle of a divide
        clear_ins(); stg_ena = 1; opcode = 7'h33; funct = {7'h01, 3'b100};
        rs1_data = 32'd1000; rs2_data = 32'd3; save_to_reg = 1; rd = 5'd9;
        step();
        repeat (10) step();
        check("middiv.busy_before", 32'(busy), 32'd1);
        #2 reset = 1;
        #1;
        check("middiv.busy", 32'(busy), 32'd0);
        check("middiv.result", result_out, 32'd0);
        check("middiv.valid", 32'(valid_out), 32'd0);
        check("middiv.rd", 32'(rd_out), 32'd0);
        check("middiv.store", store_data_out, 32'd0);
        check("middiv.target", branch_target_out, 32'd0);
        check("middiv.flags", {28'd0, save_to_reg_out, rd_memory_out, wr_memory_out,
                               branch_taken_out}, 32'd0);
        @(negedge stg_clk);
        reset = 0;
        clear_ins(); stg_ena = 1; opcode = 7'h33; rs1_data = 5; rs2_data = 32'hFFFF_FFFE;
        step();
        check("post_rst_add.result", result_out, 32'd3);
        check("post_rst_add.valid", 32'(valid_out), 32'd1);
        check("post_rst_add.busy", 32'(busy), 32'd0);

        // Randomized mix of single-cycle ops, stalls and divides
        gen_rand();
        last = model();
        step();
        check_exp("rand0", last);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                f3 = 3'($urandom_range(4, 7));
                a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 100));
                b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) b = -b;
                do_div(a, b, f3, div_model(a, b, f3), last);
            end else begin
                gen_rand();
                if ($urandom_range(0, 7) == 0) stg_ena = 0;
                else last = model();
                step();
                check_exp("rand", last);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
